// File: rtl/seq_divider_16by8.sv
// Radix-2 restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Optional fast path for zero divisor or dividend < divisor: define DIV_EARLY_TERM_EN.
module seq_divider_16by8 #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_r,     state_s;
    logic [CW-1:0] cnt_r,       cnt_s;
    logic [DW-1:0] dvd_r,       dvd_s;
    logic [VW-1:0] dvs_r,       dvs_s;
    logic [VW-1:0] rem_r,       rem_s;
    logic [DW-1:0] quotient_r,  quotient_s;
    logic [VW-1:0] remainder_r, remainder_s;
    logic          dbz_r,       dbz_s;
    logic          busy_r,      busy_s;
    logic          done_r,      done_s;

    logic [VW:0]   trial_s;
    logic [VW-1:0] diff_s;
    logic          ge_s;
    logic [VW-1:0] rem_step_s;
    logic [DW-1:0] dvd_step_s;

    // One restoring step: compare in VW+1 bits; the difference always fits VW bits when taken.
    always_comb begin
        trial_s = {rem_r, dvd_r[DW-1]};
        diff_s  = trial_s[VW-1:0] - dvs_r;
        ge_s    = (trial_s >= {1'b0, dvs_r});
        if (ge_s) begin
            rem_step_s = diff_s;
        end else begin
            rem_step_s = trial_s[VW-1:0];
        end
        dvd_step_s = {dvd_r[DW-2:0], ge_s};
    end

    // Next-state and datapath update for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        dvd_s       = dvd_r;
        dvs_s       = dvs_r;
        rem_s       = rem_r;
        quotient_s  = quotient_r;
        remainder_s = remainder_r;
        dbz_s       = dbz_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    dvd_s   = dividend;
                    dvs_s   = divisor;
                    rem_s   = {VW{1'b0}};
                    cnt_s   = {CW{1'b0}};
                    state_s = ST_CALC;
`ifdef DIV_EARLY_TERM_EN
                    if (divisor == {VW{1'b0}}) begin
                        state_s     = ST_DONE;
                        quotient_s  = {DW{1'b1}};
                        remainder_s = dividend[VW-1:0];
                        dbz_s       = 1'b1;
                    end else if (dividend < DW'(divisor)) begin
                        state_s     = ST_DONE;
                        quotient_s  = {DW{1'b0}};
                        remainder_s = dividend[VW-1:0];
                        dbz_s       = 1'b0;
                    end else begin
                        state_s = ST_CALC;
                    end
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                rem_s = rem_step_s;
                dvd_s = dvd_step_s;
                if (cnt_r == CW'(DW - 1)) begin
                    state_s     = ST_DONE;
                    quotient_s  = dvd_step_s;
                    remainder_s = rem_step_s;
                    dbz_s       = (dvs_r == {VW{1'b0}});
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // State and datapath registers; reset aborts any operation without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            dvd_r       <= {DW{1'b0}};
            dvs_r       <= {VW{1'b0}};
            rem_r       <= {VW{1'b0}};
            quotient_r  <= {DW{1'b0}};
            remainder_r <= {VW{1'b0}};
            dbz_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            dvd_r       <= dvd_s;
            dvs_r       <= dvs_s;
            rem_r       <= rem_s;
            quotient_r  <= quotient_s;
            remainder_r <= remainder_s;
            dbz_r       <= dbz_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Directed self-checking bench for seq_divider_16by8 using immediate assertions.
module tb_seq_divider_16by8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int checks;
    int errors;
    int n;
    int pulses;

`ifdef DIV_EARLY_TERM_EN
    localparam int FAST_LAT = 0;
`else
    localparam int FAST_LAT = 16;
`endif

    seq_divider_16by8 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Latency is counted in edges after the accepting edge until done is seen.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] exp_q, input logic [7:0] exp_r,
                          input logic exp_z, input int exp_lat);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 16'hDEAD;
        divisor  = 8'hBE;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_q"}, {16'd0, quotient}, {16'd0, exp_q});
        check({tag, "_r"}, {24'd0, remainder}, {24'd0, exp_r});
        check({tag, "_z"}, {31'd0, div_by_zero}, {31'd0, exp_z});
        tick();
        check({tag, "_done_len"}, {30'd0, done, busy}, 32'd0);
        check({tag, "_hold"}, {16'd0, quotient}, {16'd0, exp_q});
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 8'd0;
        tick();
        tick();
        check("reset_state", {6'd0, busy, done, quotient, remainder, div_by_zero}, 32'd0);
        rst = 1'b0;
        tick();

        run_op("sq127", 16'h3F01, 8'h7F, 16'h007F, 8'h00, 1'b0, 16);
        run_op("k1000", 16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 16);
        run_op("ffff1", 16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 16);
        run_op("dbz",   16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, FAST_LAT);
        run_op("small", 16'h0005, 8'h09, 16'h0000, 8'h05, 1'b0, FAST_LAT);
        run_op("mixed", 16'hC350, 8'hC8, 16'h00FA, 8'h00, 1'b0, 16);

        // start pulsed mid-operation must be ignored
        dividend = 16'h3F01;
        divisor  = 8'h7F;
        start    = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 5) begin
                dividend = 16'h0005;
                divisor  = 8'h09;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done === 1'b1) begin
                pulses++;
                check("ign_q", {16'd0, quotient}, 32'h0000007F);
                check("ign_r", {24'd0, remainder}, 32'd0);
            end
        end
        start = 1'b0;
        check("ign_pulses", pulses, 1);

        // reset at cycle 8 of CALC aborts with no done pulse
        dividend = 16'h03E8;
        divisor  = 8'h07;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        check("rst_abort", {6'd0, busy, done, quotient, remainder, div_by_zero}, 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        check("rst_no_done", pulses, 0);
        run_op("post_rst", 16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 16);

        // reset together with start: reset wins
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 16'h1000;
        divisor  = 8'h10;
        tick();
        check("rst_start", {30'd0, busy, done}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();

        // start held high: one IDLE cycle between done and next CALC
        dividend = 16'h1000;
        divisor  = 8'h10;
        start    = 1'b1;
        tick();
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("held_lat", n, 16);
        check("held_q", {16'd0, quotient}, 32'h00000100);
        tick();
        check("held_idle", {30'd0, busy, done}, 32'd0);
        tick();
        check("held_rearm", {30'd0, busy, done}, 32'd2);
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
